// File: rtl/sequence_generator.sv
// Serial pattern transmitter: captures a pattern word and shifts it out MSB-first,
// repeating it with an idle gap. Define SEQ_GEN_PARITY_EN to append an even-parity bit.
//
// state  | meaning
// IDLE   | ready for a new transaction, line held at 0
// SEND   | shifting pattern bits out, MSB first
// PARITY | sending the even-parity bit (SEQ_GEN_PARITY_EN only)
// GAP    | idle cycles between repetitions of one transaction
module sequence_generator #(
   parameter int PATTERN_W  = 4,
   parameter int CNT_W      = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [PATTERN_W-1:0] i_pattern,
   input  logic [CNT_W-1:0]     i_repeat,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_sequence_out,
   output logic                 o_sequence_valid,
   output logic                 o_frame_done
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEND   = 2'd1;
`ifdef SEQ_GEN_PARITY_EN
   localparam logic [1:0] PARITY = 2'd2;
`endif
   localparam logic [1:0] GAP    = 2'd3;

   localparam int BIT_W = $clog2(PATTERN_W);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PATTERN_W - 1);
   // gap timer is a down-counter; terminal count 0 means the last idle cycle
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [1:0]           state;
   logic [PATTERN_W-1:0] pat_reg;
   logic [PATTERN_W-1:0] shift_reg;
   logic [CNT_W-1:0]     rep_cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic [GAP_W-1:0]     gap_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state            <= IDLE;
         pat_reg          <= '0;
         shift_reg        <= '0;
         rep_cnt          <= '0;
         bit_idx          <= '0;
         gap_cnt          <= '0;
         o_ready          <= 1'b0;
         o_sequence_out   <= 1'b0;
         o_sequence_valid <= 1'b0;
         o_frame_done     <= 1'b0;
      end else begin
         o_sequence_out   <= 1'b0;
         o_sequence_valid <= 1'b0;
         o_frame_done     <= 1'b0;
         case (state)
            IDLE: begin
               o_ready <= 1'b1;
               if (i_valid && o_ready) begin
                  o_ready   <= 1'b0;
                  pat_reg   <= i_pattern;
                  shift_reg <= i_pattern;
                  rep_cnt   <= i_repeat;
                  bit_idx   <= '0;
                  state     <= SEND;
               end
            end
            SEND: begin
               o_sequence_out   <= shift_reg[PATTERN_W-1];
               o_sequence_valid <= 1'b1;
               shift_reg        <= {shift_reg[PATTERN_W-2:0], 1'b0};
               bit_idx          <= bit_idx + 1'b1;
               if (bit_idx == BIT_LAST) begin
                  bit_idx <= '0;
`ifdef SEQ_GEN_PARITY_EN
                  state <= PARITY;
`else
                  o_frame_done <= 1'b1;
                  if (rep_cnt == '0) begin
                     state <= IDLE;
                  end else begin
                     rep_cnt   <= rep_cnt - 1'b1;
                     shift_reg <= pat_reg;
                     if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                     end else begin
                        state <= SEND;
                     end
                  end
`endif
               end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
               o_sequence_out   <= ^pat_reg;
               o_sequence_valid <= 1'b1;
               o_frame_done     <= 1'b1;
               if (rep_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  rep_cnt   <= rep_cnt - 1'b1;
                  shift_reg <= pat_reg;
                  if (GAP_CYCLES > 0) begin
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP;
                  end else begin
                     state <= SEND;
                  end
               end
            end
`endif
            GAP: begin
               if (gap_cnt == '0) state <= SEND;
               else gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench: two generators (gap 2 and gap 0) driven by the same stimulus,
// each compared cycle by cycle against a frame-list reference model.
module tb_sequence_generator;

   localparam int PW = 4;
   localparam int CW = 4;
`ifdef SEQ_GEN_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] pattern = '0;
   logic [CW-1:0] rpt = '0;
   logic          valid = 1'b0;
   logic          ready_g, out_g, sv_g, fd_g;
   logic          ready_b, out_b, sv_b, fd_b;

   int passed = 0;
   int total  = 0;

   logic [2:0] exp_g[$];
   logic [2:0] exp_b[$];

   always #5 clk = ~clk;

   sequence_generator #(.PATTERN_W(PW), .CNT_W(CW), .GAP_CYCLES(2)) dut_gap (
      .i_clk(clk), .i_rst(rst), .i_pattern(pattern), .i_repeat(rpt), .i_valid(valid),
      .o_ready(ready_g), .o_sequence_out(out_g), .o_sequence_valid(sv_g), .o_frame_done(fd_g));

   sequence_generator #(.PATTERN_W(PW), .CNT_W(CW), .GAP_CYCLES(0)) dut_b2b (
      .i_clk(clk), .i_rst(rst), .i_pattern(pattern), .i_repeat(rpt), .i_valid(valid),
      .o_ready(ready_b), .o_sequence_out(out_b), .o_sequence_valid(sv_b), .o_frame_done(fd_b));

   // expected per-cycle {valid, data, frame_done} list for one whole transaction
   function automatic void push_frames(input int which, input logic [PW-1:0] p, input int rep, input int gap);
      logic [2:0] e;
      for (int r = 0; r <= rep; r++) begin
         for (int i = 0; i < PW; i++) begin
            e = {1'b1, p[PW-1-i], (i == PW-1) && !PAR};
            if (which == 0) exp_g.push_back(e); else exp_b.push_back(e);
         end
         if (PAR) begin
            e = {1'b1, ^p, 1'b1};
            if (which == 0) exp_g.push_back(e); else exp_b.push_back(e);
         end
         if (r < rep)
            for (int g = 0; g < gap; g++)
               if (which == 0) exp_g.push_back(3'b000); else exp_b.push_back(3'b000);
      end
   endfunction

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!(ready_g && ready_b) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!(ready_g && ready_b)) begin
         total++;
         $display("FAIL %s ready_timeout got gap=%b b2b=%b want 1/1", name, ready_g, ready_b);
      end
   endtask

   task automatic check_both(input string name, input int cyc, input logic [3:0] want_g, input logic [3:0] want_b);
      logic [3:0] got;
      got = {ready_g, sv_g, out_g, fd_g};
      total++;
      if (got !== want_g)
         $display("FAIL %s gap2 cycle %0d got rdy/vld/out/done=%b want %b", name, cyc, got, want_g);
      else passed++;
      got = {ready_b, sv_b, out_b, fd_b};
      total++;
      if (got !== want_b)
         $display("FAIL %s gap0 cycle %0d got rdy/vld/out/done=%b want %b", name, cyc, got, want_b);
      else passed++;
   endtask

   task automatic run_txn(input logic [PW-1:0] p, input int rep, input bit zero_after, input string name);
      int lg, lb, lmin, n;
      logic [3:0] wg, wb;
      wait_ready(name);
      exp_g.delete();
      exp_b.delete();
      push_frames(0, p, rep, 2);
      push_frames(1, p, rep, 0);
      lg   = exp_g.size();
      lb   = exp_b.size();
      lmin = (lg < lb) ? lg : lb;
      n    = ((lg > lb) ? lg : lb) + 2;
      @(negedge clk);
      pattern = p;
      rpt     = CW'(rep);
      valid   = 1'b1;
      @(posedge clk); #1;
      // captured copy must be used from here on
      pattern = zero_after ? '0 : PW'($urandom);
      rpt     = CW'($urandom);
      check_both(name, 0, 4'b0000, 4'b0000);
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         wg = (c <= lg) ? {1'b0, exp_g[c-1]} : 4'b1000;
         wb = (c <= lb) ? {1'b0, exp_b[c-1]} : 4'b1000;
         check_both(name, c, wg, wb);
         // valid held high mid-transaction must be ignored
         if (c == lmin) valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      #1;
      check_both("reset_hold", 0, 4'b0000, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_both("reset_release", 0, 4'b0000, 4'b0000);
      @(posedge clk); #1;
      check_both("reset_first_edge", 1, 4'b1000, 4'b1000);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_both("reset_async", 0, 4'b0000, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_both("reset_recover", 1, 4'b1000, 4'b1000);
   endtask

   task automatic test_single_frame();
      run_txn(4'b1101, 0, 1'b1, "single_frame");
   endtask

   task automatic test_repeats_gap();
      run_txn(4'b1011, 2, 1'b0, "repeats_gap");
   endtask

   task automatic test_back_to_back();
      run_txn(4'b1101, 1, 1'b0, "back_to_back");
   endtask

   task automatic test_reset_mid_frame();
      wait_ready("reset_mid");
      @(negedge clk);
      pattern = 4'b1101;
      rpt     = '0;
      valid   = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_both("reset_mid_bit2", 2, 4'b0110, 4'b0110);
      #2;
      rst = 1'b1;
      #1;
      check_both("reset_mid_clear", 2, 4'b0000, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_both("reset_mid_idle", 3, 4'b1000, 4'b1000);
      run_txn(4'b1110, 0, 1'b0, "reset_mid_restart");
   endtask

   task automatic test_parity_patterns();
      run_txn(4'b1101, 0, 1'b0, "parity_1101");
      run_txn(4'b1001, 0, 1'b0, "parity_1001");
   endtask

   task automatic test_max_repeat();
      run_txn(4'b1010, (1 << CW) - 1, 1'b0, "max_repeat");
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++)
         run_txn(PW'($urandom), $urandom_range(0, 3), 1'b0, "random");
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_repeats_gap();
      test_back_to_back();
      test_reset_mid_frame();
      test_parity_patterns();
      test_max_repeat();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
